// File: rtl/matmul_pkg.sv
// Shared constants, width helpers and FSM encoding for the sequential matrix multiplier.
package matmul_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Result element width: full product plus growth for N accumulated terms.
    function automatic int unsigned calc_cw(input int unsigned n, input int unsigned dw);
        return 2 * dw + clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate slice. MATMUL_SIGNED_EN selects two's-complement operands.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          acc_en,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [CW-1:0] sum_c
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned XW = CW - PW;

    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [PW-1:0] prod_c;
    logic [CW-1:0] prod_ext_c;

`ifdef MATMUL_SIGNED_EN
    assign prod_c     = PW'($signed(a_i) * $signed(b_i));
    assign prod_ext_c = {{XW{prod_c[PW-1]}}, prod_c};
`else
    assign prod_c     = PW'(a_i * b_i);
    assign prod_ext_c = {{XW{1'b0}}, prod_c};
`endif

    assign sum_c = acc_q + prod_ext_c;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = sum_c;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier, one MAC per enabled cycle (k inner, j, then i).
// Optional build macro: MATMUL_SIGNED_EN (signed elements).
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             start,
    input  logic [0:N*N*DW-1]                A_mat,
    input  logic [0:N*N*DW-1]                B_mat,
    output logic [0:N*N*calc_cw(N, DW)-1]    C_mat,
    output logic                             busy,
    output logic                             valid
);

    localparam int unsigned CW = calc_cw(N, DW);
    localparam int unsigned IW = clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
    logic [0:N*N*DW-1]   a_q, a_d, b_q, b_d;
    logic [0:N*N*CW-1]   c_q, c_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                mac_clr_c, mac_en_c;
    logic [DW-1:0]       a_el_c, b_el_c;
    logic [CW-1:0]       mac_sum_c;
    int unsigned         a_base_c, b_base_c, c_base_c;

    assign a_base_c = (N * 32'(i_q) + 32'(k_q)) * DW;
    assign b_base_c = (N * 32'(k_q) + 32'(j_q)) * DW;
    assign c_base_c = (N * 32'(i_q) + 32'(j_q)) * CW;
    assign a_el_c   = a_q[a_base_c +: DW];
    assign b_el_c   = b_q[b_base_c +: DW];

    matmul_mac #(
        .DW (DW),
        .CW (CW)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mac_clr_c),
        .acc_en  (mac_en_c),
        .a_i     (a_el_c),
        .b_i     (b_el_c),
        .sum_c   (mac_sum_c)
    );

    // Next-state, index walk and result write-back.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        valid_d   = valid_q;
        mac_clr_c = 1'b0;
        mac_en_c  = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_RUN;
                        a_d       = A_mat;
                        b_d       = B_mat;
                        i_d       = '0;
                        j_d       = '0;
                        k_d       = '0;
                        c_d       = '0;
                        valid_d   = 1'b0;
                        mac_clr_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    mac_en_c = 1'b1;
                    if (k_q == LAST) begin
                        c_d[c_base_c +: CW] = mac_sum_c;
                        mac_clr_c = 1'b1;
                        k_d       = '0;
                        if (j_q == LAST) begin
                            j_d = '0;
                            if (i_q == LAST) begin
                                i_d     = '0;
                                state_d = ST_DONE;
                                valid_d = 1'b1;
                            end else begin
                                i_d = i_q + IW'(1);
                            end
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign C_mat = c_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed and random checks of matmul_seq against an arithmetic matrix-product model.
module tb_matmul_seq;
    import matmul_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = calc_cw(N, DW);
    localparam int unsigned NE = N * N;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              start;
    logic [0:NE*DW-1]  A_mat;
    logic [0:NE*DW-1]  B_mat;
    logic [0:NE*CW-1]  C_mat;
    logic              busy;
    logic              valid;

    int vectors = 0;
    int errors  = 0;
    int a_v[NE];
    int b_v[NE];
    logic [CW-1:0] exp_c[NE];

    matmul_seq #(.N(N), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .start   (start),
        .A_mat   (A_mat),
        .B_mat   (B_mat),
        .C_mat   (C_mat),
        .busy    (busy),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    function automatic int to_val(input int raw);
`ifdef MATMUL_SIGNED_EN
        return (raw >= (1 << (DW - 1))) ? raw - (1 << DW) : raw;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_and_model();
        for (int e = 0; e < int'(NE); e++) begin
            A_mat[e*DW +: DW] = DW'(a_v[e]);
            B_mat[e*DW +: DW] = DW'(b_v[e]);
        end
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                int s;
                s = 0;
                for (int k = 0; k < int'(N); k++) begin
                    s += to_val(a_v[r*N+k]) * to_val(b_v[k*N+c]);
                end
                exp_c[r*N+c] = CW'(s);
            end
        end
    endtask

    task automatic check_c(input string tag);
        for (int e = 0; e < int'(NE); e++) begin
            check(tag, 64'(C_mat[e*CW +: CW]), 64'(exp_c[e]));
        end
    endtask

    task automatic check_c_zero(input string tag);
        for (int e = 0; e < int'(NE); e++) begin
            check(tag, 64'(C_mat[e*CW +: CW]), 64'd0);
        end
    endtask

    task automatic randomize_ab();
        for (int e = 0; e < int'(NE); e++) begin
            a_v[e] = int'($urandom_range(0, 255));
            b_v[e] = int'($urandom_range(0, 255));
        end
    endtask

    // Starts a multiply; optional restart attempt, enable pause, or mid-run reset.
    task automatic run_mult(input int restart_at, input int off_at, input int off_len,
                            input int rst_at, input int exp_cycles, input string tag);
        int cnt;
        load_and_model();
        enable = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        check({tag, "_valid_clr"}, 64'(valid), 64'd0);
        cnt = 0;
        while (!valid && cnt < 200) begin
            enable  = !(cnt >= off_at && cnt < off_at + off_len);
            start   = (cnt == restart_at);
            if (cnt == restart_at) A_mat = ~A_mat;
            reset_n = !(cnt == rst_at);
            @(negedge clk);
            cnt++;
            if (off_len > 0 && cnt == off_at + 3) begin
                check({tag, "_busy_paused"}, 64'(busy), 64'd1);
            end
            if (cnt == rst_at + 1) begin
                reset_n = 1'b1;
                check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                check({tag, "_rst_valid"}, 64'(valid), 64'd0);
                check_c_zero({tag, "_rst_c"});
                return;
            end
        end
        start   = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b1;
        check({tag, "_cycles"}, 64'(cnt), 64'(exp_cycles));
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check_c({tag, "_c"});
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        start   = 1'b1;
        A_mat   = '1;
        B_mat   = '1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check_c_zero("reset_c");
        start   = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Identity times 1..9 yields B.
        for (int e = 0; e < int'(NE); e++) begin
            a_v[e] = ((e / N) == (e % N)) ? 1 : 0;
            b_v[e] = e + 1;
        end
        run_mult(-1, -1, 0, -1, 27, "ident");
        for (int e = 0; e < int'(NE); e++) begin
            check("ident_eq_b", 64'(C_mat[e*CW +: CW]), 64'(e + 1));
        end

        // Result holds in DONE; start with enable low is ignored.
        repeat (3) @(negedge clk);
        check("hold_valid", 64'(valid), 64'd1);
        check_c("hold_c");
        enable = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        enable = 1'b1;
        check("en_off_start_busy", 64'(busy), 64'd0);
        check("en_off_start_valid", 64'(valid), 64'd1);

        // Full-scale operands.
        for (int e = 0; e < int'(NE); e++) begin
            a_v[e] = 255;
            b_v[e] = 255;
        end
        run_mult(-1, -1, 0, -1, 27, "max");
`ifndef MATMUL_SIGNED_EN
        for (int e = 0; e < int'(NE); e++) begin
            check("max_195075", 64'(C_mat[e*CW +: CW]), 64'd195075);
        end
`endif

        // Restart attempt during RUN is ignored.
        randomize_ab();
        run_mult(5, -1, 0, -1, 27, "restart");

        // Five-cycle enable pause stretches latency to 32.
        randomize_ab();
        run_mult(-1, 10, 5, -1, 32, "pause");

        // Mid-run reset, then a clean multiply.
        randomize_ab();
        run_mult(-1, -1, 0, 12, 0, "midrst");
        randomize_ab();
        run_mult(-1, -1, 0, -1, 27, "after_rst");

        // Reset together with start resolves to reset.
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_valid", 64'(valid), 64'd0);
        check_c_zero("rst_start_c");

        for (int t = 0; t < 4; t++) begin
            randomize_ab();
            run_mult(-1, -1, 0, -1, 27, "rand");
        end

`ifdef MATMUL_SIGNED_EN
        for (int e = 0; e < int'(NE); e++) begin
            a_v[e] = 128;
            b_v[e] = 127;
        end
        run_mult(-1, -1, 0, -1, 27, "sneg");
        for (int e = 0; e < int'(NE); e++) begin
            check("sneg_m48768", 64'(C_mat[e*CW +: CW]), 64'(CW'(-48768)));
        end
        for (int e = 0; e < int'(NE); e++) begin
            a_v[e] = 128;
            b_v[e] = 128;
        end
        run_mult(-1, -1, 0, -1, 27, "spos");
        for (int e = 0; e < int'(NE); e++) begin
            check("spos_49152", 64'(C_mat[e*CW +: CW]), 64'd49152);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
